data_mem: RTL and testbench

Memory-stage data memory for the five-stage pipelined CPU. It sits directly downstream of the E/M pipeline register and consumes the execute-stage ALU result as the effective byte address, with the forwarded rt value as store data. It performs word, halfword and byte loads and stores with sign or zero extension. Stores commit synchronously on the clock edge and each one is logged for comparison against the reference simulator. Load data is produced combinationally and goes to the M/W pipeline register.

---
 rtl/data_mem_pkg.sv | 43 ++++
 rtl/data_mem_load_ext.sv | 35 +++
 rtl/data_mem.sv | 78 +++++++
 tb/tb_data_mem.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared load/store opcode constants and decode helpers for the M-stage data memory.
package data_mem_pkg;

    // Load/store opcodes (Instr[31:26]); OP_ prefix keeps them apart from ALU op names.
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;

    typedef enum logic [3:0] {
        MEM_NONE,
        MEM_LW,
        MEM_LH,
        MEM_LHU,
        MEM_LB,
        MEM_LBU,
        MEM_SW,
        MEM_SH,
        MEM_SB
    } mem_op_e;

    // Only the opcode field is decoded, so the rest of the instruction may be anything.
    function automatic mem_op_e decode_op(input logic [5:0] opcode);
        mem_op_e op;
        case (opcode)
            OP_LW:   op = MEM_LW;
            OP_LH:   op = MEM_LH;
            OP_LHU:  op = MEM_LHU;
            OP_LB:   op = MEM_LB;
            OP_LBU:  op = MEM_LBU;
            OP_SW:   op = MEM_SW;
            OP_SH:   op = MEM_SH;
            OP_SB:   op = MEM_SB;
            default: op = MEM_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/data_mem_load_ext.sv
// Lane extraction and sign/zero extension of the word read from the data array.
module load_ext
    import data_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [5:0]  opcode,
    output logic [31:0] rd
);

    logic [15:0] half_val;
    logic [7:0]  byte_val;

    // Pick the addressed halfword/byte and extend it according to the load type.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        rd       = '0;
        half_val = offset[1] ? word[31:16] : word[15:0];
        case (offset)
            2'd0:    byte_val = word[7:0];
            2'd1:    byte_val = word[15:8];
            2'd2:    byte_val = word[23:16];
            default: byte_val = word[31:24];
        endcase
        case (decode_op(opcode))
            MEM_LW:  rd = word;
            MEM_LH:  rd = {{16{half_val[15]}}, half_val};
            MEM_LHU: rd = {16'h0000, half_val};
            MEM_LB:  rd = {{24{byte_val[7]}}, byte_val};
            MEM_LBU: rd = {24'h000000, byte_val};
            default: rd = '0;
        endcase
    end

endmodule

// File: rtl/data_mem.sv
// M-stage data memory: combinational loads, byte-enabled synchronous stores with a store log.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_M,
    input  logic [31:0] PC_M,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    output logic [31:0] RD
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [0:DEPTH-1];
    logic [ADDR_W-1:0] idx;
    logic [31:0]       old_word;
    logic [3:0]        be;
    logic [31:0]       lane_data;
    logic [31:0]       merged;
    mem_op_e           op;

    // Upper address bits wrap away and the non-opcode instruction bits are don't-care.
    logic unused_bits;
    assign unused_bits = ^{Instr_M[25:0], Addr[31:ADDR_W+2]};

    assign idx      = Addr[ADDR_W+1:2];
    assign old_word = mem[idx];

    load_ext u_load_ext (
        .word   (old_word),
        .offset (Addr[1:0]),
        .opcode (Instr_M[31:26]),
        .rd     (RD)
    );

    // Byte enables and replicated store data, then merge into the currently stored word.
    always_comb begin
        op        = decode_op(Instr_M[31:26]);
        be        = 4'b0000;
        lane_data = WD;
        case (op)
            MEM_SW: be = 4'b1111;
            MEM_SH: begin
                be        = Addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{WD[15:0]}};
            end
            MEM_SB: begin
                be        = 4'b0001 << Addr[1:0];
                lane_data = {4{WD[7:0]}};
            end
            default: be = 4'b0000;
        endcase
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? lane_data[8*i +: 8] : old_word[8*i +: 8];
        end
    end

    // Array update: full clear on reset, otherwise commit the merged store word and log it.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the architectural state must read as zero after reset, so every word is cleared in one edge.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (|be) begin
            // NOTE: non-blocking so any same-edge reader sees the pre-store word.
            mem[idx] <= merged;
`ifndef SYNTHESIS
            $display("@%h: *%h <= %h", PC_M, {Addr[31:2], 2'b00}, merged);
`endif
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: byte-addressed reference model plus directed literal checks.
module tb_data_mem;

    localparam int ADDR_W = 10;
    localparam int BYTES  = 4 << ADDR_W;

    localparam logic [5:0] LW = 6'b100011, LH = 6'b100001, LHU = 6'b100101;
    localparam logic [5:0] LB = 6'b100000, LBU = 6'b100100;
    localparam logic [5:0] SW = 6'b101011, SH = 6'b101001, SB = 6'b101000;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;

    int n_checks = 0;
    int n_errors = 0;

    // Reference memory kept as a flat little-endian byte array.
    logic [7:0] mb [BYTES];

    data_mem #(.ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .Instr_M (instr),
        .PC_M    (pc),
        .Addr    (addr),
        .WD      (wd),
        .RD      (rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] i, input logic [31:0] a);
        int b;
        logic [15:0] h;
        b = int'(a % BYTES);
        case (i[31:26])
            LW: begin
                b = b & ~3;
                return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
            end
            LH, LHU: begin
                b = b & ~1;
                h = {mb[b+1], mb[b]};
                return (i[31:26] == LH) ? {{16{h[15]}}, h} : {16'h0, h};
            end
            LB:  return {{24{mb[b][7]}}, mb[b]};
            LBU: return {24'h0, mb[b]};
            default: return 32'h0;
        endcase
    endfunction

    // Reference state update at each rising edge.
    always @(posedge clk) begin
        int b;
        b = int'(addr % BYTES);
        if (reset) begin
            for (int k = 0; k < BYTES; k++) mb[k] = 8'h00;
        end else begin
            case (instr[31:26])
                SW: begin
                    b = b & ~3;
                    for (int k = 0; k < 4; k++) mb[b+k] = wd[8*k +: 8];
                end
                SH: begin
                    b = b & ~1;
                    mb[b]   = wd[7:0];
                    mb[b+1] = wd[15:8];
                end
                SB: mb[b] = wd[7:0];
                default: ;
            endcase
        end
    end

    // Every cycle, RD must equal what the reference memory says.
    always @(negedge clk) begin
        check("rd_model", rd, model_rd(instr, addr));
    end

    task automatic drive(input logic r, input logic [31:0] i, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] p);
        @(posedge clk);
        #1;
        reset = r;
        instr = i;
        addr  = a;
        wd    = d;
        pc    = p;
    endtask

    task automatic st(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] p);
        drive(1'b0, {op, 26'h0}, a, d, p);
    endtask

    task automatic ld(input string name, input logic [5:0] op, input logic [31:0] a,
                      input logic [31:0] exp);
        drive(1'b0, {op, 26'h0}, a, 32'h0, 32'h0);
        @(negedge clk);
        check(name, rd, exp);
    endtask

    initial begin
        reset = 1'b1;
        instr = 32'h0;
        addr  = 32'h0;
        wd    = 32'h0;
        pc    = 32'h0;

        // Reset with a store presented: suppressed, array cleared.
        drive(1'b1, {SW, 26'h0}, 32'h0, 32'hDEADBEEF, 32'h2FFC);
        @(negedge clk);
        check("rd_store_in_reset", rd, 32'h0);
        ld("reset_lw0", LW, 32'h0, 32'h0);
        ld("reset_lwlast", LW, 32'hFFC, 32'h0);

        // sw then lw; RD of the store cycle itself is 0.
        st(SW, 32'h10, 32'h12345678, 32'h3000);
        @(negedge clk);
        check("rd_during_sw", rd, 32'h0);
        ld("sw_lw", LW, 32'h10, 32'h12345678);

        // Two byte stores into one word, low bits of WD only.
        st(SB, 32'h21, 32'hCAFE00AA, 32'h3004);
        st(SB, 32'h23, 32'h000000BB, 32'h3008);
        ld("sb_word", LW, 32'h20, 32'hBB00AA00);
        ld("lb_23", LB, 32'h23, 32'hFFFFFFBB);
        ld("lbu_23", LBU, 32'h23, 32'h000000BB);
        ld("lb_21", LB, 32'h21, 32'hFFFFFFAA);
        ld("lbu_20", LBU, 32'h20, 32'h00000000);

        // Halfword store into high half.
        st(SH, 32'h42, 32'hFFFF8001, 32'h300C);
        ld("sh_word", LW, 32'h40, 32'h80010000);
        ld("lh_42", LH, 32'h42, 32'hFFFF8001);
        ld("lhu_42", LHU, 32'h42, 32'h00008001);
        ld("lh_40", LH, 32'h40, 32'h00000000);
        ld("lh_43", LH, 32'h43, 32'hFFFF8001);
        st(SH, 32'h40, 32'h00007FFE, 32'h3010);
        ld("sh_low_word", LW, 32'h40, 32'h80017FFE);

        // Wrap-around and last word.
        st(SW, 32'h1000, 32'h00000055, 32'h3014);
        ld("wrap_lw0", LW, 32'h0, 32'h00000055);
        st(SW, 32'hFFC, 32'hCAFEF00D, 32'h3018);
        ld("last_lw", LW, 32'hFFC, 32'hCAFEF00D);
        ld("last_lw_alias", LW, 32'h1FFC, 32'hCAFEF00D);

        // Non-memory instruction: addu with memory-looking operands.
        drive(1'b0, {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100001}, 32'h10, 32'hFFFFFFFF, 32'h301C);
        @(negedge clk);
        check("addu_rd", rd, 32'h0);
        ld("addu_nochange", LW, 32'h10, 32'h12345678);

        // Garbage outside the opcode field is ignored.
        drive(1'b0, {LW, 26'bx}, 32'h10, 32'h0, 32'h3020);
        @(negedge clk);
        check("lw_xbits", rd, 32'h12345678);

        // Back-to-back stores to the same word apply in order.
        st(SW, 32'h80, 32'h11111111, 32'h3024);
        st(SW, 32'h80, 32'h22222222, 32'h3028);
        ld("b2b_sw", LW, 32'h80, 32'h22222222);
        st(SB, 32'h81, 32'h000000C3, 32'h302C);
        st(SB, 32'h82, 32'h0000003C, 32'h3030);
        ld("b2b_sb", LW, 32'h80, 32'h223CC322);

        // Bubble, then reset again with a store presented.
        drive(1'b0, 32'h0, 32'h80, 32'h12345678, 32'h3034);
        drive(1'b1, {SH, 26'h0}, 32'h10, 32'hFFFFFFFF, 32'h3038);
        ld("reset2_lw10", LW, 32'h10, 32'h0);
        ld("reset2_lw0", LW, 32'h0, 32'h0);
        ld("reset2_lwlast", LW, 32'hFFC, 32'h0);

        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
